// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Boot-time program loader. Receives a little-endian byte stream
//   (word count N, N program words, XOR checksum) over a valid/ready
//   handshake, writes each assembled word into the instruction memory
//   write port and holds the core in reset until the image is verified.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   in_valid    in_data holds a byte
//   in_data     stream byte
//   in_ready    loader accepts a byte (transfer on in_valid & in_ready)
//   reload      one-cycle restart request, honoured in DONE/ERROR only
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_addr   byte address of the word being written
//   imem_wd     word being written
//   core_reset  core reset, released only after a verified load
//   done        image loaded and checksum matched
//   error       load failed
//   error_code  01 length overflow, 10 checksum mismatch, 00 otherwise
module instr_mem_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code
);

  typedef enum logic [2:0] {
    StLen,
    StData,
    StCsum,
    StDone,
    StError
  } stateT;

  localparam logic [32:0]         MaxWords = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WordOne  = (ADDR_WIDTH+1)'(1);

  stateT                state;
  stateT                nextState;
  logic [1:0]           byteCnt;
  logic [23:0]          byteBuf;
  logic [ADDR_WIDTH:0]  nWords;
  logic [ADDR_WIDTH:0]  wordCnt;
  logic [31:0]          csum;
  logic [1:0]           errCode;

  logic        xfer;
  logic        lastByte;
  logic [31:0] fullWord;
  logic        lenOverflow;
  logic        lastWord;

  // Bytes arrive LSB first and shift in from the top, so after three
  // bytes the buffer holds {b2,b1,b0} and the fourth completes the word.
  assign xfer        = in_valid & in_ready;
  assign lastByte    = xfer & (byteCnt == 2'd3);
  assign fullWord    = {in_data, byteBuf};
  assign lenOverflow = {1'b0, fullWord} > MaxWords;
  assign lastWord    = (wordCnt + WordOne) == nWords;

  always_ff @(posedge clk) begin
    if (reset) state <= StLen;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    case (state)
      StLen: begin
        in_ready = ~reset;
        if (lastByte) begin
          if (lenOverflow)          nextState = StError;
          else if (fullWord == '0)  nextState = StCsum;
          else                      nextState = StData;
        end
      end
      StData: begin
        in_ready = ~reset;
        if (lastByte && lastWord) nextState = StCsum;
      end
      StCsum: begin
        in_ready = ~reset;
        if (lastByte) nextState = (fullWord == csum) ? StDone : StError;
      end
      StDone, StError: begin
        if (reload) nextState = StLen;
      end
      default: nextState = StLen;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byteCnt   <= '0;
      byteBuf   <= '0;
      nWords    <= '0;
      wordCnt   <= '0;
      csum      <= '0;
      errCode   <= '0;
      imem_we   <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wd   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        byteCnt <= byteCnt + 2'd1;
        byteBuf <= fullWord[31:8];
      end
      case (state)
        StLen: begin
          if (lastByte) begin
            nWords <= fullWord[ADDR_WIDTH:0];
            if (lenOverflow) errCode <= 2'b01;
          end
        end
        StData: begin
          if (lastByte) begin
            imem_we   <= 1'b1;
            imem_addr <= BASE_ADDR + (32'(wordCnt) << 2);
            imem_wd   <= fullWord;
            csum      <= csum ^ fullWord;
            wordCnt   <= wordCnt + WordOne;
          end
        end
        StCsum: begin
          if (lastByte && (fullWord != csum)) errCode <= 2'b10;
        end
        StDone, StError: begin
          if (reload) begin
            byteCnt <= '0;
            wordCnt <= '0;
            csum    <= '0;
            errCode <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done       = (state == StDone);
  assign error      = (state == StError);
  assign core_reset = (state != StDone);
  assign error_code = errCode;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int          AW   = 6;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXN = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [1:0]  error_code;

  instr_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .core_reset(core_reset),
    .done(done), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int unsigned wrCyc[$];
  int unsigned acceptCyc[$];
  logic [31:0] imgWords[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wrAddr.push_back(imem_addr);
      wrData.push_back(imem_wd);
      wrCyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int unsigned gap);
    int unsigned waited;
    logic rdy;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $error("FAIL handshake_timeout observed=%0d expected=ready", waited);
        break;
      end
    end
    in_valid = 1'b0;
    acceptCyc.push_back(cyc);
  endtask

  task automatic doReload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_error", 32'(error), 32'd0);
    chk("reload_code", 32'(error_code), 32'd0);
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Sends an image built from imgWords (ignored when n overflows) and
  // checks status timing, write list and write latency against the model.
  task automatic runImage(input logic [31:0] n, input bit useOverride,
                          input logic [31:0] csumOverride,
                          input int unsigned gapMin, input int unsigned gapMax,
                          input bit midGap);
    logic [7:0]  bq[$];
    logic [31:0] expCsum, csumSent, w;
    bit          ovf, expDone;
    int unsigned expWrites, gap;
    logic [1:0]  expCode;

    wrAddr.delete(); wrData.delete(); wrCyc.delete(); acceptCyc.delete();
    ovf     = (n > MAXN);
    expCsum = '0;
    if (!ovf) foreach (imgWords[k]) expCsum ^= imgWords[k];
    csumSent = useOverride ? csumOverride : expCsum;
    expDone  = !ovf && (csumSent == expCsum);
    expCode  = ovf ? 2'b01 : (expDone ? 2'b00 : 2'b10);
    expWrites = ovf ? 0 : n;

    w = n;
    for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
    if (!ovf) begin
      for (int unsigned k = 0; k < n; k++) begin
        w = imgWords[k];
        for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
      end
      w = csumSent;
      for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
    end

    foreach (bq[i]) begin
      gap = $urandom_range(gapMax, gapMin);
      if (midGap && i == 6) gap += 10;
      sendByte(bq[i], gap);
    end

    @(negedge clk);
    chk("status_done", 32'(done), 32'(expDone));
    chk("status_error", 32'(error), 32'(!expDone));
    chk("status_code", 32'(error_code), 32'(expCode));
    chk("status_core_reset", 32'(core_reset), 32'(!expDone));
    chk("status_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("write_count", wrAddr.size(), expWrites);
    for (int unsigned k = 0; k < wrAddr.size() && k < expWrites; k++) begin
      chk("write_addr", wrAddr[k], BASE + 4 * k);
      chk("write_data", wrData[k], imgWords[k]);
      chk("write_latency", wrCyc[k], acceptCyc[4 + 4*k + 3]);
    end
    @(posedge clk); #1;
  endtask

  task automatic randWords(input int unsigned n);
    imgWords.delete();
    for (int unsigned k = 0; k < n; k++) imgWords.push_back($urandom);
  endtask

  task automatic nominalWords();
    imgWords.delete();
    imgWords.push_back(32'h0050_0093);
    imgWords.push_back(32'h0010_0113);
  endtask

  initial begin
    int unsigned kind, n;
    logic [31:0] x;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_code", 32'(error_code), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wd", imem_wd, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_core_reset", 32'(core_reset), 32'd1);
    chk("post_rst_addr", imem_addr, BASE);
    @(posedge clk); #1;

    // Nominal load
    nominalWords();
    runImage(32'd2, 1'b1, 32'h0040_0180, 0, 0, 1'b0);
    chk("nominal_done", 32'(done), 32'd1);

    // Bad checksum
    doReload();
    nominalWords();
    runImage(32'd2, 1'b1, 32'h0000_0000, 0, 0, 1'b0);

    // Length overflow, then a full-memory image
    doReload();
    runImage(32'd65, 1'b0, 32'h0, 0, 0, 1'b0);
    doReload();
    randWords(MAXN);
    runImage(MAXN, 1'b0, 32'h0, 0, 2, 1'b0);

    // Throttled input with a long gap inside word 0
    doReload();
    nominalWords();
    runImage(32'd2, 1'b0, 32'h0, 1, 1, 1'b1);

    // Reset mid-load, with a byte offered during the reset cycle
    doReload();
    wrAddr.delete();
    for (int i = 0; i < 6; i++) begin
      x = (i == 0) ? 32'd2 : ((i == 4) ? 32'h93 : 32'h0);
      sendByte(x[7:0], 0);
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_writes", wrAddr.size(), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk); #1;
    nominalWords();
    runImage(32'd2, 1'b0, 32'h0, 0, 0, 1'b0);

    // Empty image
    doReload();
    imgWords.delete();
    runImage(32'd0, 1'b1, 32'h0, 0, 0, 1'b0);
    doReload();

    // Randomized images
    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(3, 0);
      if (kind == 3) begin
        x = ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFF : 32'(MAXN + 1 + $urandom_range(1000, 0));
        runImage(x, 1'b0, 32'h0, 0, 2, 1'b0);
      end else begin
        n = $urandom_range(MAXN, 0);
        randWords(n);
        if (kind == 2) begin
          x = '0;
          foreach (imgWords[k]) x ^= imgWords[k];
          x ^= 32'(1) << $urandom_range(31, 0);
          runImage(n, 1'b1, x, 0, 3, 1'b0);
        end else begin
          runImage(n, 1'b0, 32'h0, 0, 3, 1'b0);
        end
      end
      doReload();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
